gshare_branch_predictor: RTL and testbench

//  Parametrised direction predictor for the fetch stage: table of saturating counters indexed by PC
//  (optionally XOR global history), prediction = counter MSB. Fetch gets a prediction plus the index it

---
 rtl/bp_pkg.sv | 13 +
 rtl/sat_counter_next.sv | 22 ++
 rtl/gshare_branch_predictor.sv | 98 +++++++++
 tb/tb_gshare_branch_predictor.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared encodings and default geometry for the branch direction predictor.
// Latency: n/a (declarations only); backpressure: n/a.
package bp_pkg;

   typedef enum logic {
      BP_INIT = 1'b0,
      BP_RUN  = 1'b1
   } bp_state_e;

   localparam int BP_INDEX_BITS = 6;
   localparam int BP_CTR_BITS   = 2;

endpackage

// File: rtl/sat_counter_next.sv
// Next value of a saturating up/down counter: +1 on taken, -1 on not-taken, clamped at both ends.
// Latency: combinational; backpressure: none.
module sat_counter_next
   import bp_pkg::*;
#(
   parameter int CTR_BITS = BP_CTR_BITS
) (
   input  logic [CTR_BITS-1:0] ctr,
   input  logic                taken,
   output logic [CTR_BITS-1:0] ctr_next
);

   always_comb begin
      ctr_next = ctr;
      if (taken) begin
         if (ctr != '1) ctr_next = ctr + 1'b1;
      end else begin
         if (ctr != '0) ctr_next = ctr - 1'b1;
      end
   end

endmodule

// File: rtl/gshare_branch_predictor.sv
// Bimodal/gshare direction predictor; `BP_GSHARE_EN adds a global history XORed into the index.
// Latency: prediction is zero-cycle combinational, updates land at the next edge; backpressure: none.
module gshare_branch_predictor
   import bp_pkg::*;
#(
   parameter int INDEX_BITS = BP_INDEX_BITS,
   parameter int CTR_BITS   = BP_CTR_BITS,
   parameter int HIST_BITS  = 6,
   parameter int CTR_INIT   = 2**(CTR_BITS-1)-1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           pc,
   output logic                  prediction,
   output logic [INDEX_BITS-1:0] pred_index,
   output logic                  ready,
   input  logic                  update_enable,
   input  logic [INDEX_BITS-1:0] update_index,
   input  logic                  actual_taken
);

   localparam int ENTRIES = 1 << INDEX_BITS;

   bp_state_e             state_q, state_d;
   logic [INDEX_BITS-1:0] ptr_q, ptr_d;
   logic [CTR_BITS-1:0]   ctr_table_q [ENTRIES];

   logic [INDEX_BITS-1:0] base_idx;
   logic                  wr_en;
   logic [INDEX_BITS-1:0] wr_idx;
   logic [CTR_BITS-1:0]   wr_ctr;
   logic [CTR_BITS-1:0]   upd_ctr_next;
   logic                  unused_pc_bits;

   assign base_idx       = pc[INDEX_BITS+1:2];
   assign unused_pc_bits = ^{pc[31:INDEX_BITS+2], pc[1:0]};

`ifdef BP_GSHARE_EN
   logic [HIST_BITS-1:0] ghr_q, ghr_d;

   assign pred_index = base_idx ^ INDEX_BITS'(ghr_q);

   // History shifts only on resolved branches, so no speculative repair is needed.
   always_comb begin
      ghr_d = ghr_q;
      if (state_q == BP_RUN && update_enable) ghr_d = HIST_BITS'({ghr_q, actual_taken});
   end

   always_ff @(posedge clk) begin
      if (rst) ghr_q <= '0;
      else     ghr_q <= ghr_d;
   end
`else
   assign pred_index = base_idx;
`endif

   sat_counter_next #(.CTR_BITS(CTR_BITS)) u_ctr_next (
      .ctr      (ctr_table_q[update_index]),
      .taken    (actual_taken),
      .ctr_next (upd_ctr_next)
   );

   // Single write port: the init sweep owns it until the last entry is written.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      wr_en   = 1'b0;
      wr_idx  = update_index;
      wr_ctr  = upd_ctr_next;
      if (state_q == BP_INIT) begin
         wr_en  = 1'b1;
         wr_idx = ptr_q;
         wr_ctr = CTR_BITS'(CTR_INIT);
         ptr_d  = ptr_q + 1'b1;
         if (ptr_q == '1) state_d = BP_RUN;
      end else begin
         wr_en = update_enable;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= BP_INIT;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) ctr_table_q[wr_idx] <= wr_ctr;
   end

   assign ready      = (state_q == BP_RUN);
   assign prediction = ready & ctr_table_q[pred_index][CTR_BITS-1];

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed checks of reset sweep, counter training/saturation, same-cycle ordering and reset restart.
module tb_gshare_branch_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc, pc1;
   logic        prediction, pred1;
   logic [5:0]  pred_index, pidx1;
   logic        ready, ready1;
   logic        update_enable, upd_en1;
   logic [5:0]  update_index, upd_idx1;
   logic        actual_taken, taken1;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   gshare_branch_predictor u_dut (
      .clk(clk), .rst(rst), .pc(pc), .prediction(prediction), .pred_index(pred_index),
      .ready(ready), .update_enable(update_enable), .update_index(update_index),
      .actual_taken(actual_taken)
   );

   gshare_branch_predictor #(.CTR_BITS(3)) u_dut3 (
      .clk(clk), .rst(rst), .pc(pc1), .prediction(pred1), .pred_index(pidx1),
      .ready(ready1), .update_enable(upd_en1), .update_index(upd_idx1),
      .actual_taken(taken1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic upd0(input logic [5:0] idx, input logic tk);
      update_enable = 1'b1;
      update_index  = idx;
      actual_taken  = tk;
      tick();
      update_enable = 1'b0;
   endtask

   task automatic upd1(input logic [5:0] idx, input logic tk);
      upd_en1  = 1'b1;
      upd_idx1 = idx;
      taken1   = tk;
      tick();
      upd_en1  = 1'b0;
   endtask

   // Counts edges from rst release until ready; optional ignored update pulses on idx 16.
   task automatic wait_ready(input string tag, input bit pulse);
      int cnt = 0;
      while (!ready && cnt < 200) begin
         if (pulse && cnt >= 30 && cnt < 34) begin
            update_enable = 1'b1;
            update_index  = 6'd16;
            actual_taken  = 1'b1;
         end else begin
            update_enable = 1'b0;
         end
         tick();
         cnt++;
      end
      update_enable = 1'b0;
      check(tag, cnt, 64);
   endtask

   initial begin
      int bad;
      rst = 1'b1; pc = '0; pc1 = '0;
      update_enable = 1'b0; update_index = '0; actual_taken = 1'b0;
      upd_en1 = 1'b0; upd_idx1 = '0; taken1 = 1'b0;
      tick(); tick();
      check("reset_ready", ready, 0);
      check("reset_pred", prediction, 0);
      rst = 1'b0;
      tick();
      check("init_ready_low", ready, 0);
      check("init_pred_zero", prediction, 0);
      // one edge already taken above, so 63 more expected
      begin
         int cnt = 1;
         while (!ready && cnt < 200) begin tick(); cnt++; end
         check("init_cycles", cnt, 64);
      end
      check("ready_ctr3", ready1, 1);

      bad = 0;
      for (int i = 0; i < 64; i++) begin
         pc = 32'(i) << 2;
         #1;
         if (prediction !== 1'b0 || pred_index !== 6'(i)) bad++;
      end
      check("post_init_all_pred0", bad, 0);

`ifndef BP_GSHARE_EN
      pc = 32'h40;
      #1;
      check("idx16", pred_index, 16);
      upd0(16, 1); check("t1_pred", prediction, 1);
      upd0(16, 1); upd0(16, 1);
      upd0(16, 0); check("sat_hi_nt1", prediction, 1);
      upd0(16, 0); check("sat_hi_nt2", prediction, 0);
      upd0(16, 1); upd0(16, 1);
      upd0(16, 0); upd0(16, 0); upd0(16, 0); upd0(16, 0);
      check("nt4_pred", prediction, 0);
      upd0(16, 0); check("nt5_pred", prediction, 0);
      upd0(16, 1); check("from00_t1", prediction, 0);
      upd0(16, 1); check("from00_t2", prediction, 1);

      pc = 32'h50;
      update_enable = 1'b1; update_index = 6'd20; actual_taken = 1'b1;
      #1;
      check("same_cycle_old", prediction, 0);
      tick();
      update_enable = 1'b0;
      check("same_cycle_next", prediction, 1);

      pc1 = 32'h40;
      #1;
      check("c3_init_pred", pred1, 0);
      upd1(16, 1); check("c3_t1", pred1, 1);
      upd1(16, 1); upd1(16, 1); upd1(16, 1); upd1(16, 1);
      upd1(16, 0); check("c3_nt1", pred1, 1);
      upd1(16, 0); check("c3_nt2", pred1, 1);
      upd1(16, 0); check("c3_nt3", pred1, 1);
      upd1(16, 0); check("c3_nt4", pred1, 0);

      pc = 32'h40;
      upd0(16, 1);
      check("train_11", prediction, 1);
      rst = 1'b1; tick(); rst = 1'b0;
      check("rst_run_ready", ready, 0);
      for (int i = 0; i < 19; i++) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      check("rst_mid_ready", ready, 0);
      wait_ready("resweep_cycles", 1'b1);
      check("resweep_pred", prediction, 0);
      upd0(16, 1); check("resweep_t1", prediction, 1);
      upd0(16, 0); check("resweep_nt1", prediction, 0);
`else
      upd0(5, 1); upd0(5, 1);
      pc = 32'h14;
      update_enable = 1'b1; update_index = 6'd6; actual_taken = 1'b1;
      #1;
      check("gs_idx6", pred_index, 6);
      check("gs_pred6_old", prediction, 0);
      tick();
      update_enable = 1'b0;
      check("gs_idx_after", pred_index, 2);
      pc = 32'h08; #1;
      check("gs_idx5", pred_index, 5);
      check("gs_ctr5_kept", prediction, 1);
      pc = 32'h04; #1;
      check("gs_idx6b", pred_index, 6);
      check("gs_ctr6_taken", prediction, 1);
      rst = 1'b1; tick(); rst = 1'b0;
      wait_ready("gs_resweep", 1'b1);
      pc = 32'h14; #1;
      check("gs_ghr_cleared", pred_index, 5);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not reach summary");
      $fatal(1);
   end

endmodule
